// File: rtl/csi2_test_pattern_src.sv
// rtl/csi2_test_pattern_src.sv - CSI-2 byte-domain test-pattern frame source (optional TPG_FRAME_CNT_EN).
// Emits FS, NUM_LINES RAW8 long packets of 64-bit beats, then FE, each behind the glue handshake.
module csi2_test_pattern_src #(
    parameter int NUM_PIXELS = 240,
    parameter int NUM_LINES  = 4,
    parameter int PIX_WIDTH  = 8,
    parameter int LINE_GAP   = 16,
    parameter int FRAME_GAP  = 256
) (
    input  logic        byte_clk_i,
    input  logic        reset_byte_n_i,
    input  logic        enable_i,
    input  logic [1:0]  pattern_sel_i,
    input  logic        c2d_ready_i,
    input  logic        txfr_en_i,
    output logic        txfr_req_o,
    output logic        fv_start_o,
    output logic        fv_end_o,
    output logic        byte_en_o,
    output logic [63:0] byte_data_o,
`ifdef TPG_FRAME_CNT_EN
    output logic        busy_o,
    output logic [15:0] frame_cnt_o
`else
    output logic        busy_o
`endif
);

    localparam int BEATS   = NUM_PIXELS * PIX_WIDTH / 64;
    localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW      = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int GAP_MAX = (FRAME_GAP > LINE_GAP) ? FRAME_GAP : LINE_GAP;
    localparam int GW      = $clog2(GAP_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_C2D, S_REQ, S_WAIT_EN, S_SEND_FS,
        S_SEND_LINE, S_SEND_FE, S_WAIT_DONE, S_GAP
    } state_t;

    typedef enum logic [1:0] {K_FS, K_LINE, K_FE} kind_t;

    state_t          state, next_state;
    kind_t           kind;
    logic [LW-1:0]   line_cnt;
    logic [BW-1:0]   beat_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [1:0]      pat_sel;
    logic [7:0]      frame_lsb;
    logic            last_beat;
    logic [BW-1:0]   next_beat;
    logic [63:0]     data_d;

    assign last_beat = (beat_cnt == BW'(BEATS - 1));

    function automatic logic [7:0] pix_val(input logic [1:0] sel, input int x,
                                           input logic [7:0] y, input logic [7:0] f);
        int bar;
        bar = (x * 8) / NUM_PIXELS;
        case (sel)
            2'd0:    pix_val = x[7:0];
            2'd1:    pix_val = y;
            2'd2:    pix_val = {bar[2:0], 5'd0};
            default: pix_val = x[7:0] + y + f;
        endcase
    endfunction

    always_ff @(posedge byte_clk_i or negedge reset_byte_n_i) begin
        if (!reset_byte_n_i) state <= S_IDLE;
        else                 state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (enable_i) next_state = S_WAIT_C2D;
            S_WAIT_C2D:  if (c2d_ready_i) next_state = S_REQ;
            S_REQ:       next_state = S_WAIT_EN;
            S_WAIT_EN: begin
                if (txfr_en_i) begin
                    case (kind)
                        K_FS:    next_state = S_SEND_FS;
                        K_LINE:  next_state = S_SEND_LINE;
                        default: next_state = S_SEND_FE;
                    endcase
                end
            end
            S_SEND_FS:   next_state = S_WAIT_DONE;
            S_SEND_FE:   next_state = S_WAIT_DONE;
            S_SEND_LINE: if (last_beat) next_state = S_WAIT_DONE;
            S_WAIT_DONE: if (!txfr_en_i) next_state = S_GAP;
            S_GAP:       if (gap_cnt <= GW'(1)) next_state = (kind == K_FE) ? S_IDLE : S_WAIT_C2D;
            default:     next_state = S_IDLE;
        endcase
    end

    // Counters and packet-kind sequencing.
    always_ff @(posedge byte_clk_i or negedge reset_byte_n_i) begin
        if (!reset_byte_n_i) begin
            kind     <= K_FS;
            line_cnt <= '0;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            pat_sel  <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable_i) begin
                        pat_sel  <= pattern_sel_i;
                        kind     <= K_FS;
                        line_cnt <= '0;
                    end
                end
                S_SEND_LINE: beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                S_WAIT_DONE: begin
                    if (!txfr_en_i)
                        gap_cnt <= (kind == K_FE) ? GW'(FRAME_GAP) : GW'(LINE_GAP);
                end
                S_GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                    if (gap_cnt <= GW'(1)) begin
                        case (kind)
                            K_FS: begin
                                kind     <= K_LINE;
                                line_cnt <= '0;
                            end
                            K_LINE: begin
                                if (line_cnt == LW'(NUM_LINES - 1)) kind <= K_FE;
                                else                                line_cnt <= line_cnt + 1'b1;
                            end
                            default: kind <= K_FS;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TPG_FRAME_CNT_EN
    always_ff @(posedge byte_clk_i or negedge reset_byte_n_i) begin
        if (!reset_byte_n_i)         frame_cnt_o <= 16'd0;
        else if (state == S_SEND_FE) frame_cnt_o <= frame_cnt_o + 16'd1;
    end
    assign frame_lsb = frame_cnt_o[7:0];
`else
    assign frame_lsb = 8'd0;
`endif

    // Beat data is built for the beat the next state will present, so the
    // output register moves data and flags on the same edge as the state.
    always_comb begin
        next_beat = (state == S_SEND_LINE) ? beat_cnt + 1'b1 : '0;
        data_d    = 64'd0;
        for (int k = 0; k < 8; k++)
            data_d[8*k +: 8] = pix_val(pat_sel, 32'(next_beat) * 8 + k, 8'(line_cnt), frame_lsb);
    end

    always_ff @(posedge byte_clk_i or negedge reset_byte_n_i) begin
        if (!reset_byte_n_i) begin
            txfr_req_o  <= 1'b0;
            fv_start_o  <= 1'b0;
            fv_end_o    <= 1'b0;
            byte_en_o   <= 1'b0;
            byte_data_o <= 64'd0;
            busy_o      <= 1'b0;
        end else begin
            txfr_req_o  <= (next_state == S_REQ);
            fv_start_o  <= (next_state == S_SEND_FS);
            fv_end_o    <= (next_state == S_SEND_FE);
            byte_en_o   <= (next_state == S_SEND_LINE);
            byte_data_o <= (next_state == S_SEND_LINE) ? data_d : 64'd0;
            busy_o      <= (next_state != S_IDLE);
        end
    end

endmodule
